stage3: RTL and testbench
=========================

STAGE3 -- requirements
Module: stage3

Interface
REQ-001 SHALL have parameter IN_W, default 15, input component width (signed two's complement).
REQ-002 SHALL have parameter OUT_W, default 16, output component width, fixed at IN_W+1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-high (asserted when 1) despite the name.
REQ-005 SHALL have port valid_i  input  1  input sample valid; once raised it stays high for the whole stream, including flush samples.
REQ-006 SHALL have port data_in_r  input  IN_W  signed real part of the input sample.
REQ-007 SHALL have port data_in_i  input  IN_W  signed imaginary part of the input sample.
REQ-008 SHALL have port valid_o  output  1  output sample valid.
REQ-009 SHALL have port data_out_r  output  OUT_W  signed real part of the output sample.
REQ-010 SHALL have port data_out_i  output  OUT_W  signed imaginary part of the output sample.

Function
REQ-011 SHALL implement stage 3 of a 32-point radix-2 DIF single-path delay-feedback FFT: butterfly span 4, input blocks of 8 samples.
REQ-012 SHALL keep a 3-bit phase counter p that is cleared by reset and increments, mod 8, on every cycle with valid_i=1; it holds when valid_i=0.
REQ-013 SHALL keep a 4-entry complex delay line, each entry OUT_W bits per component, that shifts only on valid_i=1 cycles.
REQ-014 In phases p=0..3, SHALL push the sign-extended input into the delay line and output the popped entry, which is the twiddled difference from the previous block.
REQ-015 In phases p=4..7, with a = popped x[n] and b = input x[n+4], SHALL output a+b and push (a-b)*W(k), where k=p-4.
REQ-016 SHALL compute a+b and a-b at OUT_W bits, with no overflow possible.
REQ-017 SHALL apply twiddles as follows, with c=181 (0.7071 in Q8).
  - W0 = 1: pass-through.
  - W2 = -j: r'=i, i'=-r.
  - W1: r'=sat((c*(r+i))>>>8), i'=sat((c*(i-r))>>>8).
  - W3: r'=sat((c*(i-r))>>>8), i'=sat(-((c*(r+i))>>>8)).
  - Shifts SHALL be arithmetic (floor).
  - Intermediate products SHALL be wide enough not to wrap.
  - sat() SHALL clamp to the OUT_W signed range.
REQ-018 The output order per block SHALL be: sums n=0..3, then twiddled differences n=0..3, the latter emitted during the next block's phases 0..3.
REQ-019 Outputs SHALL be registered: data selected on a valid_i cycle appears on data_out_* one cycle later.
REQ-020 SHALL keep a primed flag that is set on the first valid_i cycle with p=4 and cleared only by reset.
REQ-021 valid_o SHALL equal the registered value of (valid_i AND (primed OR p=4)). The first valid_o therefore occurs 5 cycles after the first input sample.
REQ-022 Draining the last block's differences SHALL require 4 further valid_i samples; their values (typically zero) are ignored as data.
REQ-023 When valid_i=0, SHALL hold the counter, delay line and data outputs, and drive valid_o=0 on the next cycle.

Reset
REQ-024 When rst_n=1 at a clock edge, SHALL set the following to 0: p, primed, all delay-line entries, valid_o, data_out_r and data_out_i.
REQ-025 Reset mid-stream SHALL discard all in-flight data; the next valid_i sample is treated as block sample 0.
REQ-026 Reset SHALL take priority over valid_i in the same cycle.

Structure
REQ-027 A shared package SHALL hold IN_W, OUT_W, the constant c=181, the Q shift of 8, and a complex-sample typedef {re, im}.
REQ-028 The twiddle multiply and saturation SHALL be a sub-module fft_twiddle_w8, taking k[1:0] and a complex OUT_W input and returning a complex OUT_W output, purely combinational.
REQ-029 The delay line, phase counter and output register SHALL reside in stage3.

Verification
REQ-030 Impulse block [1,0,0,0,0,0,0,0] (real), then 4 zeros -> outputs 1,0,0,0,1,0,0,0 (imag all 0), with first valid_o 5 cycles after the first input.
REQ-031 Block with x[1]=100 only, plus flush -> output index 1 = 100, and output index 5 = (70, -71).
REQ-032 Block with x[2]=100 -> output index 6 = (0, -100); block with x[3]=100 -> output index 7 = (-71, -70).
REQ-033 x[1]=16383+j16383, x[5]=-16384-j16384 -> output index 1 = (-1, -1), and output index 5 = (32767, 0) with saturation.
REQ-034 Four back-to-back blocks (32 samples) followed by 4 flush samples -> exactly 32 valid_o cycles, contiguous.
REQ-035 Reset pulse after sample 6 of a block -> valid_o=0 next cycle; restarting the stream reproduces the REQ-030 result.

Source files
------------

// File: rtl/stage3_pkg.sv
// Shared widths, twiddle constants and complex sample type for FFT stage 3.
package stage3_pkg;

    localparam int IN_W    = 15;
    localparam int OUT_W   = IN_W + 1;
    localparam int TW_C    = 181;
    localparam int Q_SHIFT = 8;
    localparam int PROD_W  = OUT_W + 12;

    typedef struct packed {
        logic signed [OUT_W-1:0] re;
        logic signed [OUT_W-1:0] im;
    } cplx_t;

    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (OUT_W - 1)));

    // Clamp a wide intermediate into the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] sat(input logic signed [PROD_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/stage3_if.sv
// Sample stream bundle for stage 3: master drives input samples, slave returns outputs.
interface stage3_if;
    import stage3_pkg::*;

    logic                    valid_i;
    logic signed [IN_W-1:0]  data_in_r;
    logic signed [IN_W-1:0]  data_in_i;
    logic                    valid_o;
    logic signed [OUT_W-1:0] data_out_r;
    logic signed [OUT_W-1:0] data_out_i;

    modport master (
        output valid_i, data_in_r, data_in_i,
        input  valid_o, data_out_r, data_out_i
    );

    modport slave (
        input  valid_i, data_in_r, data_in_i,
        output valid_o, data_out_r, data_out_i
    );

endinterface

// File: rtl/fft_twiddle_w8.sv
// Combinational multiply by W8^k (k = 0..3) with Q8 coefficient and saturation.
module fft_twiddle_w8
    import stage3_pkg::*;
(
    input  logic [1:0] k,
    input  cplx_t      x,
    output cplx_t      y
);

    localparam logic signed [PROD_W-1:0] C_W = PROD_W'(TW_C);

    logic signed [PROD_W-1:0] r_w;
    logic signed [PROD_W-1:0] i_w;
    logic signed [PROD_W-1:0] s_w;
    logic signed [PROD_W-1:0] d_w;
    logic signed [PROD_W-1:0] ps_sh;
    logic signed [PROD_W-1:0] pd_sh;

    always_comb begin
        r_w   = PROD_W'($signed(x.re));
        i_w   = PROD_W'($signed(x.im));
        s_w   = r_w + i_w;
        d_w   = i_w - r_w;
        // Products are formed at PROD_W so they cannot wrap before the floor shift.
        ps_sh = (s_w * C_W) >>> Q_SHIFT;
        pd_sh = (d_w * C_W) >>> Q_SHIFT;
        y     = x;
        unique case (k)
            2'd1: begin
                y.re = sat(ps_sh);
                y.im = sat(pd_sh);
            end
            2'd2: begin
                y.re = x.im;
                y.im = sat(-r_w);
            end
            2'd3: begin
                y.re = sat(pd_sh);
                y.im = sat(-ps_sh);
            end
            default: y = x;
        endcase
    end

endmodule

// File: rtl/stage3.sv
// Stage 3 of a 32-point radix-2 DIF SDF FFT: span-4 butterfly with 4-entry feedback delay line.
module stage3 #(
    parameter int IN_W  = stage3_pkg::IN_W,
    parameter int OUT_W = IN_W + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    input  logic signed [IN_W-1:0]  data_in_r,
    input  logic signed [IN_W-1:0]  data_in_i,
    output logic                    valid_o,
    output logic signed [OUT_W-1:0] data_out_r,
    output logic signed [OUT_W-1:0] data_out_i
);
    import stage3_pkg::*;

    logic [2:0] p;
    logic       primed;
    cplx_t      dl [4];

    cplx_t x_in;
    cplx_t pop;
    cplx_t sum;
    cplx_t diff;
    cplx_t diff_tw;
    cplx_t sel;
    cplx_t push;

    fft_twiddle_w8 u_tw (
        .k (p[1:0]),
        .x (diff),
        .y (diff_tw)
    );

    always_comb begin
        x_in.re = {{(OUT_W-IN_W){data_in_r[IN_W-1]}}, data_in_r};
        x_in.im = {{(OUT_W-IN_W){data_in_i[IN_W-1]}}, data_in_i};
        pop     = dl[3];
        sum.re  = pop.re + x_in.re;
        sum.im  = pop.im + x_in.im;
        diff.re = pop.re - x_in.re;
        diff.im = pop.im - x_in.im;
        // Upper half-block butterflies; lower half forwards the previous block's differences.
        if (p[2]) begin
            sel  = sum;
            push = diff_tw;
        end else begin
            sel  = pop;
            push = x_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            p          <= '0;
            primed     <= 1'b0;
            dl[0]      <= '0;
            dl[1]      <= '0;
            dl[2]      <= '0;
            dl[3]      <= '0;
            valid_o    <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else begin
            valid_o <= valid_i & (primed | (p == 3'd4));
            if (valid_i) begin
                p <= p + 3'd1;
                if (p == 3'd4) begin
                    primed <= 1'b1;
                end
                dl[0]      <= push;
                dl[1]      <= dl[0];
                dl[2]      <= dl[1];
                dl[3]      <= dl[2];
                data_out_r <= sel.re;
                data_out_i <= sel.im;
            end
        end
    end

endmodule

// File: tb/tb_stage3.sv
// Directed bench for stage3: hand-computed butterfly/twiddle outputs, hold, reset and stream framing.
module tb_stage3;
    import stage3_pkg::*;

    typedef int arr8_t [8];

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stage3_if bus ();

    stage3 #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .rst_n      (rst),
        .valid_i    (bus.valid_i),
        .data_in_r  (bus.data_in_r),
        .data_in_i  (bus.data_in_i),
        .valid_o    (bus.valid_o),
        .data_out_r (bus.data_out_r),
        .data_out_i (bus.data_out_i)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic step(input logic v, input int r, input int i);
        bus.valid_i   = v;
        bus.data_in_r = r[IN_W-1:0];
        bus.data_in_i = i[IN_W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int v, input int er, input int ei);
        chk({tag, ".valid"}, int'(bus.valid_o), v);
        chk({tag, ".re"}, int'($signed(bus.data_out_r)), er);
        chk({tag, ".im"}, int'($signed(bus.data_out_i)), ei);
    endtask

    // Reset with valid_i high to exercise reset priority.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        step(1'b1, 7, 7);
        rst = 1'b0;
        chk_out(tag, 0, 0, 0);
    endtask

    task automatic run_block(input string tag, input arr8_t xr, input arr8_t xi,
                             input arr8_t er, input arr8_t ei);
        for (int n = 0; n < 8; n++) begin
            step(1'b1, xr[n], xi[n]);
            if (n >= 4)
                chk_out($sformatf("%s[%0d]", tag, n - 4), 1, er[n-4], ei[n-4]);
            else
                chk($sformatf("%s.pre%0d.valid", tag, n), int'(bus.valid_o), 0);
        end
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 0, 0);
            chk_out($sformatf("%s[%0d]", tag, n + 4), 1, er[n+4], ei[n+4]);
        end
    endtask

    arr8_t xr, xi, er, ei, zero8;
    int    nvalid, first_idx, last_idx, first_re, last_re, last_im;

    initial begin
        zero8         = '{default: 0};
        bus.valid_i   = 1'b0;
        bus.data_in_r = '0;
        bus.data_in_i = '0;
        step(1'b0, 0, 0);

        // Impulse: sums then differences, first valid_o on the fifth sample.
        do_reset("rst0");
        xr = '{1, 0, 0, 0, 0, 0, 0, 0};
        er = '{1, 0, 0, 0, 1, 0, 0, 0};
        run_block("imp", xr, zero8, er, zero8);

        // Single tone in x[1]: W1 floor rounding.
        do_reset("rst1");
        xr = '{0, 100, 0, 0, 0, 0, 0, 0};
        er = '{0, 100, 0, 0, 0, 70, 0, 0};
        ei = '{0, 0, 0, 0, 0, -71, 0, 0};
        run_block("x1", xr, zero8, er, ei);

        // x[2]: W2 = -j.
        do_reset("rst2");
        xr = '{0, 0, 100, 0, 0, 0, 0, 0};
        er = '{0, 0, 100, 0, 0, 0, 0, 0};
        ei = '{0, 0, 0, 0, 0, 0, -100, 0};
        run_block("x2", xr, zero8, er, ei);

        // x[3]: W3.
        do_reset("rst3");
        xr = '{0, 0, 0, 100, 0, 0, 0, 0};
        er = '{0, 0, 0, 100, 0, 0, 0, -71};
        ei = '{0, 0, 0, 0, 0, 0, 0, -70};
        run_block("x3", xr, zero8, er, ei);

        // Full-scale inputs: sum at range edge, saturated W1 difference.
        do_reset("rst4");
        xr = '{0, 16383, 0, 0, 0, -16384, 0, 0};
        xi = '{0, 16383, 0, 0, 0, -16384, 0, 0};
        er = '{0, -1, 0, 0, 0, 32767, 0, 0};
        ei = '{0, -1, 0, 0, 0, 0, 0, 0};
        run_block("sat", xr, xi, er, ei);

        // Complex pair in x[0]/x[4].
        do_reset("rst5");
        xr = '{5, 0, 0, 0, 3, 0, 0, 0};
        xi = '{2, 0, 0, 0, 7, 0, 0, 0};
        er = '{8, 0, 0, 0, 2, 0, 0, 0};
        ei = '{9, 0, 0, 0, -5, 0, 0, 0};
        run_block("cpx", xr, xi, er, ei);

        // valid_i gap: outputs hold, valid_o drops, phase does not advance.
        do_reset("rst6");
        step(1'b1, 1, 0);
        for (int n = 1; n < 4; n++) step(1'b1, 0, 0);
        step(1'b1, 0, 0);
        chk_out("gap.sum0", 1, 1, 0);
        step(1'b0, 5, 5);
        chk_out("gap.idle", 0, 1, 0);
        for (int n = 5; n < 8; n++) step(1'b1, 0, 0);
        chk_out("gap.sum3", 1, 0, 0);
        step(1'b1, 0, 0);
        chk_out("gap.diff0", 1, 1, 0);

        // Mid-block reset discards in-flight data; restart reproduces impulse result.
        do_reset("rst7");
        step(1'b1, 1, 0);
        for (int n = 1; n < 6; n++) step(1'b1, 0, 0);
        rst = 1'b1;
        step(1'b1, 9, 9);
        rst = 1'b0;
        chk_out("midrst", 0, 0, 0);
        xr = '{1, 0, 0, 0, 0, 0, 0, 0};
        er = '{1, 0, 0, 0, 1, 0, 0, 0};
        run_block("imp2", xr, zero8, er, zero8);

        // Four back-to-back blocks x[n]=n+1 plus flush: 32 contiguous valid_o cycles.
        do_reset("rst8");
        nvalid    = 0;
        first_idx = -1;
        last_idx  = -1;
        first_re  = 0;
        last_re   = 0;
        last_im   = 0;
        for (int s = 0; s < 36; s++) begin
            if (s < 32) step(1'b1, (s % 8) + 1, 0);
            else        step(1'b1, 0, 0);
            if (bus.valid_o) begin
                if (first_idx < 0) begin
                    first_idx = s;
                    first_re  = int'($signed(bus.data_out_r));
                end
                last_idx = s;
                last_re  = int'($signed(bus.data_out_r));
                last_im  = int'($signed(bus.data_out_i));
                nvalid++;
            end
        end
        chk("stream.count", nvalid, 32);
        chk("stream.first", first_idx, 4);
        chk("stream.span", last_idx - first_idx + 1, 32);
        chk("stream.first_re", first_re, 6);
        chk("stream.last_re", last_re, 2);
        chk("stream.last_im", last_im, 3);
        step(1'b0, 0, 0);
        chk("stream.idle.valid", int'(bus.valid_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
